// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - registered RV32I decode stage producing the ALU control/operand bundle
// One pipeline register with valid/ready handshake and synchronous flush.
module alu_ctrl_decode (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_opsel,
  output logic        o_sub,
  output logic        o_unsigned,
  output logic        o_arith,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic [31:0] o_store_data,
  output logic [4:0]  o_rd,
  output logic        o_rd_wen,
  output logic        o_is_branch,
  output logic        o_is_jal,
  output logic        o_is_jalr,
  output logic [2:0]  o_funct3,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];
  assign rd     = i_inst[11:7];

  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  logic [2:0]  d_opsel;
  logic        d_sub, d_unsigned, d_arith;
  logic [31:0] d_op1, d_op2, d_imm;
  logic        d_rd_wen, d_branch, d_jal, d_jalr, d_mem_rd, d_mem_wr, d_illegal;

  always_comb begin
    d_opsel    = 3'b000;
    d_sub      = 1'b0;
    d_unsigned = 1'b0;
    d_arith    = 1'b0;
    d_imm      = imm_i;
    d_op1      = i_rs1_data;
    d_op2      = imm_i;
    d_rd_wen   = 1'b0;
    d_branch   = 1'b0;
    d_jal      = 1'b0;
    d_jalr     = 1'b0;
    d_mem_rd   = 1'b0;
    d_mem_wr   = 1'b0;
    d_illegal  = 1'b0;
    // Opcodes all end in 2'b11, so a bad inst[1:0] falls through to default.
    case (opcode)
      OPC_LUI: begin
        d_imm = imm_u; d_op1 = 32'd0; d_op2 = imm_u; d_rd_wen = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = imm_u; d_op1 = i_pc; d_op2 = imm_u; d_rd_wen = 1'b1;
      end
      OPC_JAL: begin
        d_imm = imm_j; d_op1 = i_pc; d_op2 = 32'd4; d_rd_wen = 1'b1; d_jal = 1'b1;
      end
      OPC_JALR: begin
        d_op1 = i_pc; d_op2 = 32'd4; d_rd_wen = 1'b1; d_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        d_imm = imm_b; d_opsel = 3'b010; d_op2 = i_rs2_data;
        d_unsigned = funct3[1]; d_branch = 1'b1;
        d_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        d_mem_rd = 1'b1; d_rd_wen = 1'b1;
        d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_imm = imm_s; d_op2 = imm_s; d_mem_wr = 1'b1;
        d_illegal = (funct3[2] == 1'b1) || (funct3 == 3'b011);
      end
      OPC_OPIMM: begin
        d_opsel = funct3; d_rd_wen = 1'b1;
        d_unsigned = (funct3 == 3'b011);
        d_arith = (funct3 == 3'b101) && i_inst[30];
        if (funct3 == 3'b001)
          d_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          d_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        d_opsel = funct3; d_op2 = i_rs2_data; d_rd_wen = 1'b1;
        d_unsigned = (funct3 == 3'b011);
        d_sub   = (funct3 == 3'b000) && i_inst[30];
        d_arith = (funct3 == 3'b101) && i_inst[30];
        if (funct7 == 7'b0100000)
          d_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        else
          d_illegal = (funct7 != 7'b0000000);
      end
      default: d_illegal = 1'b1;
    endcase
    // An illegal instruction still travels down the pipe, but must not act.
    if (d_illegal) begin
      d_opsel  = 3'b000;
      d_sub    = 1'b0;
      d_arith  = 1'b0;
      d_rd_wen = 1'b0;
      d_branch = 1'b0;
      d_jal    = 1'b0;
      d_jalr   = 1'b0;
      d_mem_rd = 1'b0;
      d_mem_wr = 1'b0;
    end
    if (rd == 5'd0) d_rd_wen = 1'b0;
  end

  logic xfer_in;
  assign o_ready = !o_valid || i_ready;
  assign xfer_in = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_opsel      <= 3'b000;
      o_sub        <= 1'b0;
      o_unsigned   <= 1'b0;
      o_arith      <= 1'b0;
      o_op1        <= 32'd0;
      o_op2        <= 32'd0;
      o_imm        <= 32'd0;
      o_pc         <= 32'd0;
      o_store_data <= 32'd0;
      o_rd         <= 5'd0;
      o_rd_wen     <= 1'b0;
      o_is_branch  <= 1'b0;
      o_is_jal     <= 1'b0;
      o_is_jalr    <= 1'b0;
      o_funct3     <= 3'b000;
      o_mem_rd     <= 1'b0;
      o_mem_wr     <= 1'b0;
      o_illegal    <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (xfer_in) begin
      o_valid      <= 1'b1;
      o_opsel      <= d_opsel;
      o_sub        <= d_sub;
      o_unsigned   <= d_unsigned;
      o_arith      <= d_arith;
      o_op1        <= d_op1;
      o_op2        <= d_op2;
      o_imm        <= d_imm;
      o_pc         <= i_pc;
      o_store_data <= i_rs2_data;
      o_rd         <= rd;
      o_rd_wen     <= d_rd_wen;
      o_is_branch  <= d_branch;
      o_is_jal     <= d_jal;
      o_is_jalr    <= d_jalr;
      o_funct3     <= funct3;
      o_mem_rd     <= d_mem_rd;
      o_mem_wr     <= d_mem_wr;
      o_illegal    <= d_illegal;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb/tb_alu_ctrl_decode.sv - directed self-checking bench for alu_ctrl_decode
module tb_alu_ctrl_decode;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_ready;
  logic [31:0] i_inst, i_pc, i_rs1_data, i_rs2_data;
  logic        o_ready, o_valid, o_sub, o_unsigned, o_arith, o_rd_wen;
  logic        o_is_branch, o_is_jal, o_is_jalr, o_mem_rd, o_mem_wr, o_illegal;
  logic [2:0]  o_opsel, o_funct3;
  logic [31:0] o_op1, o_op2, o_imm, o_pc, o_store_data;
  logic [4:0]  o_rd;

  int n_checks = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  alu_ctrl_decode dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_opsel(o_opsel), .o_sub(o_sub), .o_unsigned(o_unsigned), .o_arith(o_arith),
    .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm), .o_pc(o_pc), .o_store_data(o_store_data),
    .o_rd(o_rd), .o_rd_wen(o_rd_wen), .o_is_branch(o_is_branch), .o_is_jal(o_is_jal),
    .o_is_jalr(o_is_jalr), .o_funct3(o_funct3), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_illegal(o_illegal)
  );

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic vld);
    i_inst = inst; i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2; i_valid = vld;
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
    drive(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0);
    step(); step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    n_checks++; if (o_op2 !== 32'd0) begin n_fail++; $display("FAIL reset_op2 got=%h exp=0", o_op2); end
    n_checks++; if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", o_illegal); end
    i_rst = 1'b0;
  endtask

  task automatic test_sub();
    i_ready = 1'b1;
    drive(32'h4020_8033, 32'h100, 32'd5, 32'd7, 1'b1);
    step();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL sub_valid got=%b exp=1", o_valid); end
    n_checks++; if (o_opsel !== 3'b000) begin n_fail++; $display("FAIL sub_opsel got=%b exp=000", o_opsel); end
    n_checks++; if (o_sub !== 1'b1) begin n_fail++; $display("FAIL sub_sub got=%b exp=1", o_sub); end
    n_checks++; if (o_arith !== 1'b0) begin n_fail++; $display("FAIL sub_arith got=%b exp=0", o_arith); end
    n_checks++; if (o_op1 !== 32'd5) begin n_fail++; $display("FAIL sub_op1 got=%h exp=5", o_op1); end
    n_checks++; if (o_op2 !== 32'd7) begin n_fail++; $display("FAIL sub_op2 got=%h exp=7", o_op2); end
    n_checks++; if (o_rd !== 5'd0) begin n_fail++; $display("FAIL sub_rd got=%0d exp=0", o_rd); end
    n_checks++; if (o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL sub_rd_wen got=%b exp=0", o_rd_wen); end
    n_checks++; if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL sub_illegal got=%b exp=0", o_illegal); end
  endtask

  task automatic test_srai();
    drive(32'h4031_5093, 32'h104, 32'h8000_0000, 32'd0, 1'b1);
    step();
    n_checks++; if (o_opsel !== 3'b101) begin n_fail++; $display("FAIL srai_opsel got=%b exp=101", o_opsel); end
    n_checks++; if (o_arith !== 1'b1) begin n_fail++; $display("FAIL srai_arith got=%b exp=1", o_arith); end
    n_checks++; if (o_sub !== 1'b0) begin n_fail++; $display("FAIL srai_sub got=%b exp=0", o_sub); end
    n_checks++; if (o_op1 !== 32'h8000_0000) begin n_fail++; $display("FAIL srai_op1 got=%h exp=80000000", o_op1); end
    n_checks++; if (o_op2 !== 32'h403) begin n_fail++; $display("FAIL srai_op2 got=%h exp=403", o_op2); end
    n_checks++; if (o_rd !== 5'd1) begin n_fail++; $display("FAIL srai_rd got=%0d exp=1", o_rd); end
    n_checks++; if (o_rd_wen !== 1'b1) begin n_fail++; $display("FAIL srai_rd_wen got=%b exp=1", o_rd_wen); end
  endtask

  task automatic test_formats();
    drive(32'h1234_52B7, 32'h1000, 32'h55, 32'h66, 1'b1);  // lui x5
    step();
    n_checks++; if (o_op1 !== 32'd0) begin n_fail++; $display("FAIL lui_op1 got=%h exp=0", o_op1); end
    n_checks++; if (o_op2 !== 32'h1234_5000) begin n_fail++; $display("FAIL lui_op2 got=%h exp=12345000", o_op2); end
    n_checks++; if (o_rd_wen !== 1'b1) begin n_fail++; $display("FAIL lui_rd_wen got=%b exp=1", o_rd_wen); end
    drive(32'h1234_5297, 32'h1000, 32'h55, 32'h66, 1'b1);  // auipc x5
    step();
    n_checks++; if (o_op1 !== 32'h1000) begin n_fail++; $display("FAIL auipc_op1 got=%h exp=1000", o_op1); end
    drive(32'hFFDF_F0EF, 32'h2000, 32'h55, 32'h66, 1'b1);  // jal x1, -4
    step();
    n_checks++; if (o_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL jal_imm got=%h exp=fffffffc", o_imm); end
    n_checks++; if (o_op1 !== 32'h2000 || o_op2 !== 32'd4) begin n_fail++; $display("FAIL jal_ops got=%h/%h exp=2000/4", o_op1, o_op2); end
    n_checks++; if (o_is_jal !== 1'b1 || o_is_branch !== 1'b0) begin n_fail++; $display("FAIL jal_flags got=%b%b exp=10", o_is_jal, o_is_branch); end
    drive(32'hFF81_2183, 32'h2004, 32'h300, 32'h66, 1'b1);  // lw x3, -8(x2)
    step();
    n_checks++; if (o_imm !== 32'hFFFF_FFF8 || o_op2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL lw_imm got=%h/%h exp=fffffff8", o_imm, o_op2); end
    n_checks++; if (o_mem_rd !== 1'b1 || o_rd_wen !== 1'b1 || o_funct3 !== 3'b010) begin n_fail++; $display("FAIL lw_ctrl got=%b%b%b exp=1 1 010", o_mem_rd, o_rd_wen, o_funct3); end
    drive(32'h0051_2623, 32'h2008, 32'h300, 32'hCAFE, 1'b1);  // sw x5, 12(x2)
    step();
    n_checks++; if (o_imm !== 32'd12) begin n_fail++; $display("FAIL sw_imm got=%h exp=c", o_imm); end
    n_checks++; if (o_mem_wr !== 1'b1 || o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL sw_ctrl got=%b%b exp=10", o_mem_wr, o_rd_wen); end
    n_checks++; if (o_store_data !== 32'hCAFE) begin n_fail++; $display("FAIL sw_data got=%h exp=cafe", o_store_data); end
  endtask

  task automatic test_illegal();
    drive(32'h0000_00FF, 32'h0, 32'h1, 32'h2, 1'b1);  // opcode 0x7f, rd=x1
    step();
    n_checks++; if (o_illegal !== 1'b1) begin n_fail++; $display("FAIL ill7f_illegal got=%b exp=1", o_illegal); end
    n_checks++; if (o_rd_wen !== 1'b0 || o_mem_wr !== 1'b0) begin n_fail++; $display("FAIL ill7f_ctrl got=%b%b exp=00", o_rd_wen, o_mem_wr); end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ill7f_valid got=%b exp=1", o_valid); end
    drive(32'h4020_C0B3, 32'h0, 32'h1, 32'h2, 1'b1);  // OP f7=0100000 f3=100
    step();
    n_checks++; if (o_illegal !== 1'b1 || o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL illop_flags got=%b%b exp=10", o_illegal, o_rd_wen); end
    n_checks++; if (o_opsel !== 3'b000) begin n_fail++; $display("FAIL illop_opsel got=%b exp=000", o_opsel); end
    drive(32'h0000_2063, 32'h0, 32'h1, 32'h2, 1'b1);  // branch funct3 010
    step();
    n_checks++; if (o_illegal !== 1'b1 || o_is_branch !== 1'b0) begin n_fail++; $display("FAIL illbr_flags got=%b%b exp=10", o_illegal, o_is_branch); end
  endtask

  task automatic test_stall();
    i_ready = 1'b1;
    drive(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    i_ready = 1'b0;
    drive(32'h0020_E863, 32'h200, 32'd3, 32'd9, 1'b1);  // bltu x1, x2, +16
    step();
    for (int c = 0; c < 3; c++) begin
      drive(32'h1234_52B7 + (c << 12), 32'h300, 32'hAA, 32'hBB, 1'b1);
      #1;
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d got=%b exp=0", c, o_ready); end
      step();
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d got=%b exp=1", c, o_valid); end
      n_checks++; if (o_op1 !== 32'd3 || o_op2 !== 32'd9 || o_pc !== 32'h200) begin n_fail++; $display("FAIL stall_ops c%0d got=%h/%h/%h exp=3/9/200", c, o_op1, o_op2, o_pc); end
      n_checks++; if (o_imm !== 32'd16 || o_opsel !== 3'b010 || o_funct3 !== 3'b110) begin n_fail++; $display("FAIL stall_dec c%0d got=%h/%b/%b exp=10/010/110", c, o_imm, o_opsel, o_funct3); end
      n_checks++; if (o_unsigned !== 1'b1 || o_is_branch !== 1'b1 || o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL stall_flags c%0d got=%b%b%b exp=110", c, o_unsigned, o_is_branch, o_rd_wen); end
    end
    i_ready = 1'b1;
    drive(32'h1234_52B7, 32'h400, 32'h0, 32'h0, 1'b1);
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", o_ready); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_op2 !== 32'h1234_5000 || o_pc !== 32'h400) begin n_fail++; $display("FAIL release_next got=%b/%h/%h exp=1/12345000/400", o_valid, o_op2, o_pc); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive((32'(k) << 20) | 32'h0000_0093, 32'(k * 4), 32'h0, 32'h0, 1'b1);
      step();
      n_checks++; if (o_valid !== 1'b1 || o_imm !== 32'(k) || o_pc !== 32'(k * 4)) begin n_fail++; $display("FAIL b2b k%0d got=%b/%h/%h exp=1/%h/%h", k, o_valid, o_imm, o_pc, k, k * 4); end
    end
    drive(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    drive(32'h0050_0093, 32'h500, 32'h0, 32'h0, 1'b1);  // addi x1, x0, 5
    step();
    n_checks++; if (o_valid !== 1'b1 || o_imm !== 32'd5) begin n_fail++; $display("FAIL flush_held got=%b/%h exp=1/5", o_valid, o_imm); end
    i_flush = 1'b1;
    drive(32'h1234_52B7, 32'h600, 32'h0, 32'h0, 1'b1);
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
    i_flush = 1'b0; i_ready = 1'b1;
    drive(32'h1234_52B7, 32'h600, 32'h0, 32'h0, 1'b0);
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got=%b exp=0", o_valid); end
  endtask

  task automatic test_reset_mid_stall();
    i_ready = 1'b0;
    drive(32'h0070_0093, 32'h700, 32'h0, 32'h0, 1'b1);
    step();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_stall_held got=%b exp=1", o_valid); end
    i_rst = 1'b1;
    step();
    n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall got=%b/%b exp=0/1", o_valid, o_ready); end
    n_checks++; if (o_imm !== 32'd0 || o_pc !== 32'd0) begin n_fail++; $display("FAIL rst_stall_payload got=%h/%h exp=0/0", o_imm, o_pc); end
    i_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_srai();
    test_formats();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decode.md
# alu_ctrl_decode

Registered RV32I decode stage that turns a fetched instruction into the control and operand bundle consumed by the ALU. It drives the ALU's op-select, modifier flags and both operands, plus the branch, memory and writeback controls that travel with them. It sits between fetch/register-file read and execute as one pipeline register with a valid/ready handshake and a flush input.

## Interface

Parameters:

- none

Ports (name, direction, width, meaning):

- i_clk in 1: clock, rising edge.
- i_rst in 1: synchronous, active-high reset.
- i_valid in 1: upstream instruction valid.
- o_ready out 1: stage can accept an instruction.
- i_inst in 32: instruction word.
- i_pc in 32: PC of the instruction.
- i_rs1_data, i_rs2_data in 32 each: register-file read data, valid in the same cycle as i_inst.
- i_flush in 1: kill the held and incoming instruction.
- o_valid out 1: bundle valid to execute.
- i_ready in 1: execute accepts the bundle.
- o_opsel out 3: ALU op-select.
- o_sub, o_unsigned, o_arith out 1 each: ALU modifier flags.
- o_op1, o_op2 out 32 each: ALU operands.
- o_imm out 32: decoded immediate, sign-extended.
- o_pc out 32: registered PC.
- o_store_data out 32: registered rs2 data.
- o_rd out 5: destination register.
- o_rd_wen out 1: writeback enable.
- o_is_branch, o_is_jal, o_is_jalr out 1 each: control-flow class.
- o_funct3 out 3: raw funct3, used for the branch condition and memory size.
- o_mem_rd, o_mem_wr out 1 each: load/store.
- o_illegal out 1: instruction not decodable as RV32I.

## Operation

- Transfer in happens when i_valid && o_ready && !i_flush.
  - o_ready = !o_valid || i_ready (combinational).
- Immediates follow the RV32I encodings, all sign-extended from inst[31]:
  - I: loads, OP-IMM, JALR.
  - S: stores.
  - B: branches.
  - U: LUI, AUIPC.
  - J: JAL.
- Per-opcode decode. Default when not listed: op1 = rs1 and op2 = imm.
  - LUI: opsel 000, op1 = 0, op2 = imm, rd_wen.
  - AUIPC: opsel 000, op1 = pc, op2 = imm, rd_wen.
  - JAL and JALR: opsel 000, op1 = pc, op2 = 4 (link value), rd_wen.
  - BRANCH: opsel 010, op1 = rs1, op2 = rs2, o_unsigned = funct3[1], no rd_wen.
    - funct3 010 and 011 are illegal for branches.
  - LOAD: opsel 000, op2 = imm, mem_rd, rd_wen.
    - Legal funct3: 000, 001, 010, 100, 101.
  - STORE: opsel 000, op2 = imm, mem_wr.
    - Legal funct3: 000, 001, 010.
  - OP-IMM: opsel = funct3, op2 = imm.
    - sub is never set.
    - o_unsigned = (funct3 == 011).
    - o_arith = inst[30] only when funct3 = 101.
    - SLLI requires funct7 = 0.
    - SRLI/SRAI require funct7 = 0000000 or 0100000.
  - OP: opsel = funct3, op2 = rs2.
    - o_sub = inst[30] when funct3 = 000.
    - o_arith = inst[30] when funct3 = 101.
    - o_unsigned = (funct3 == 011).
    - funct7 must be 0000000. 0100000 is legal only with funct3 000 or 101.
  - Any other opcode, or inst[1:0] != 11: illegal.
- An illegal instruction is still transferred with o_illegal = 1. In that case:
  - rd_wen, mem_rd, mem_wr and all control-flow flags are forced to 0.
  - opsel is 000.
- o_rd_wen is forced to 0 when rd = x0.
- Fields the instruction does not use are don't-care, except that o_sub and o_arith are 0 whenever not defined above.

## Timing

- Latency is 1 cycle: an instruction accepted at edge N is presented with o_valid = 1 after edge N.
- o_valid update on each edge:
  - Set on transfer in.
  - Otherwise cleared when i_ready = 1.
  - Held when o_valid && !i_ready. During the hold, every output is held bit-stable, and o_ready = 0.
- Back-to-back: with i_ready = 1 continuously, one instruction per cycle and no bubbles.
- i_flush (synchronous): o_valid is 0 after the edge. Any same-cycle incoming instruction is dropped. Flush wins over transfer and stall.
- Reset: o_valid = 0 and every registered output = 0. o_ready = 1 after reset (follows o_valid = 0).
  - Reset asserted mid-stall discards the held instruction.
- Payload registers load only on transfer in, so data is never corrupted by an upstream change during a stall.

## Test plan

- R-type SUB (0x40208033) with rs1 = 5, rs2 = 7, i_ready = 1. Next cycle requires:
  - opsel 000, sub 1, arith 0.
  - op1 = 5, op2 = 7.
  - rd = 0, rd_wen 0 (x0).
  - o_valid 1.
- SRAI x1, x2, 3 (0x40315093) with rs1 = 0x80000000. Requires:
  - opsel 101, arith 1, sub 0.
  - op2 = 0x403, rd = 1, rd_wen 1.
- Stall: accept BLTU (funct3 110), then hold i_ready = 0 for 3 cycles while i_inst changes. Requires:
  - o_ready = 0 throughout the stall.
  - All outputs unchanged, with unsigned 1 and is_branch 1.
  - On release, the next instruction appears one cycle later.
- Flush with i_valid = 1 and a held bundle: o_valid = 0 next cycle and the incoming instruction is lost.
- Illegal cases:
  - Opcode 0x7F: o_illegal 1, rd_wen 0, mem_wr 0.
  - OP with funct7 = 0100000 and funct3 = 100: o_illegal 1.
- Reset mid-stall: assert i_rst while o_valid = 1 and i_ready = 0. Next cycle requires o_valid = 0 and o_ready = 1.
